// File: rtl/source_streamer_pkg.sv
// rtl/source_streamer_pkg.sv - shared assembler state and ASCII constants
package source_streamer_pkg;

  typedef enum logic [1:0] {
    IDLE                = 2'd0,
    PC_MAPPING          = 2'd1,
    INSTRUCTION_MAPPING = 2'd2,
    FINISHED            = 2'd3
  } assembler_state_t;

  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_TAB   = 8'h09;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_HASH  = 8'h23;
  localparam logic [7:0] ASCII_NUL   = 8'h00;

endpackage

// File: rtl/char_normalizer.sv
// rtl/char_normalizer.sv - classifies one program text byte and normalises it
module char_normalizer
  import source_streamer_pkg::*;
(
  input  logic [7:0] raw_byte,
  input  logic       comment_mode,
  output logic       emit,
  output logic       drop,
  output logic       eol,
  output logic       eof,
  output logic       comment_start,
  output logic [7:0] norm_byte
);

  always_comb begin
    emit          = 1'b0;
    drop          = 1'b0;
    eol           = 1'b0;
    eof           = 1'b0;
    comment_start = 1'b0;
    norm_byte     = raw_byte;
    // Line and file terminators win over comment mode
    if (raw_byte == ASCII_NUL) begin
      eof = 1'b1;
    end else if (raw_byte == ASCII_LF) begin
      eol = 1'b1;
    end else if (comment_mode || raw_byte == ASCII_CR) begin
      drop = 1'b1;
    end else if (raw_byte == ASCII_HASH) begin
      drop          = 1'b1;
      comment_start = 1'b1;
    end else begin
      emit = 1'b1;
      if (raw_byte == ASCII_TAB) norm_byte = ASCII_SPACE;
    end
  end

endmodule

// File: rtl/source_streamer.sv
// rtl/source_streamer.sv - replays program text from BRAM twice as paced line/character pulses
module source_streamer
  import source_streamer_pkg::*;
#(
  parameter int CHAR_PER_LINE = 64,
  parameter int NUMBER_LINES  = 256,
  parameter int BRAM_LATENCY  = 2,
  parameter int CHAR_GAP      = 4,
  localparam int ADDR_W = $clog2(CHAR_PER_LINE * NUMBER_LINES),
  localparam int LINE_W = $clog2(NUMBER_LINES),
  localparam int CHAR_W = $clog2(CHAR_PER_LINE)
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              start_in,
  output logic [ADDR_W-1:0] text_addr,
  input  logic [7:0]        text_data,
  output logic              new_line,
  output logic              new_character,
  output logic [7:0]        incoming_character,
  output logic [LINE_W-1:0] line_count,
  output logic [CHAR_W-1:0] char_count,
  output assembler_state_t  assembler_state,
  input  logic              error_in,
  output logic              busy,
  output logic              done,
  output logic              error_flag,
  output logic [LINE_W-1:0] error_line
);

  localparam int GAP_W = $clog2(CHAR_GAP + 1);
  localparam int LAT_W = $clog2(BRAM_LATENCY + 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(CHAR_PER_LINE * NUMBER_LINES - 1);
  localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(NUMBER_LINES - 1);
  localparam logic [CHAR_W:0]   CHAR_FULL = (CHAR_W + 1)'(CHAR_PER_LINE);
  localparam logic [GAP_W-1:0]  GAP_FULL  = GAP_W'(CHAR_GAP);
  localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(BRAM_LATENCY - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_LINE, S_FETCH, S_DECODE, S_EMIT, S_GAP, S_EOL, S_EOF, S_SWITCH, S_FINISH
  } state_t;

  state_t state, state_nx, ret_state, ret_nx;
  logic [CHAR_W:0]  chars;
  logic [GAP_W-1:0] gap_cnt;
  logic [LAT_W-1:0] lat_cnt;
  logic [7:0]       emit_byte, char_val, nz_byte;
  logic first_line, closing, comment_mode;
  logic gap_ok, fire_line, fire_char, addr_inc, ret_load, set_closing, overflow, abort;
  logic accept, restart;
  logic nz_emit, nz_drop, nz_eol, nz_eof, nz_comment;

  char_normalizer u_norm (
    .raw_byte      (text_data),
    .comment_mode  (comment_mode),
    .emit          (nz_emit),
    .drop          (nz_drop),
    .eol           (nz_eol),
    .eof           (nz_eof),
    .comment_start (nz_comment),
    .norm_byte     (nz_byte)
  );

  assign gap_ok  = (gap_cnt >= GAP_FULL);
  assign accept  = (state == S_IDLE) && start_in;
  assign restart = (state == S_SWITCH) && (state_nx == S_LINE);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    fire_line   = 1'b0;
    fire_char   = 1'b0;
    char_val    = ASCII_SPACE;
    addr_inc    = 1'b0;
    ret_load    = 1'b0;
    ret_nx      = S_FETCH;
    set_closing = 1'b0;
    overflow    = 1'b0;
    case (state)
      S_IDLE: if (start_in) state_nx = S_LINE;
      S_LINE: if (gap_ok) begin
        if (!first_line && line_count == LINE_LAST) overflow = 1'b1;
        else begin
          fire_line = 1'b1;
          state_nx  = closing ? S_SWITCH : S_FETCH;
        end
      end
      S_FETCH: if (lat_cnt == LAT_LAST) state_nx = S_DECODE;
      S_DECODE: begin
        if (nz_eof || text_addr == ADDR_LAST) state_nx = S_EOF;
        else if (nz_eol)                      state_nx = S_EOL;
        else if (nz_emit)                     state_nx = S_EMIT;
        else if (nz_drop) begin
          addr_inc = 1'b1;
          state_nx = S_FETCH;
        end
      end
      S_EMIT: if (gap_ok) begin
        if (chars == CHAR_FULL) overflow = 1'b1;
        else begin
          fire_char = 1'b1;
          char_val  = emit_byte;
          addr_inc  = 1'b1;
          ret_load  = 1'b1;
          state_nx  = S_GAP;
        end
      end
      S_GAP: if (gap_ok) state_nx = ret_state;
      // Line end: trailing delimiter only for lines that emitted something
      S_EOL, S_EOF: begin
        set_closing = (state == S_EOF);
        if (chars == '0) begin
          addr_inc = (state == S_EOL);
          state_nx = S_LINE;
        end else if (gap_ok) begin
          if (chars == CHAR_FULL) overflow = 1'b1;
          else begin
            fire_char = 1'b1;
            addr_inc  = (state == S_EOL);
            ret_load  = 1'b1;
            ret_nx    = S_LINE;
            state_nx  = S_GAP;
          end
        end
      end
      S_SWITCH: state_nx = (assembler_state == PC_MAPPING) ? S_LINE : S_FINISH;
      S_FINISH: state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
    abort = busy && (error_in || overflow);
    if (abort) begin
      fire_line = 1'b0;
      fire_char = 1'b0;
      addr_inc  = 1'b0;
      ret_load  = 1'b0;
      if (state != S_FINISH) state_nx = S_FINISH;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      text_addr          <= '0;
      new_line           <= 1'b0;
      new_character      <= 1'b0;
      incoming_character <= '0;
      line_count         <= '0;
      char_count         <= '0;
      assembler_state    <= IDLE;
      busy               <= 1'b0;
      done               <= 1'b0;
      error_flag         <= 1'b0;
      error_line         <= '0;
      chars              <= '0;
      first_line         <= 1'b0;
      closing            <= 1'b0;
      comment_mode       <= 1'b0;
      emit_byte          <= '0;
      gap_cnt            <= '0;
      lat_cnt            <= '0;
      ret_state          <= S_FETCH;
    end else begin
      new_line      <= fire_line;
      new_character <= fire_char;
      done          <= 1'b0;
      lat_cnt       <= (state == S_FETCH) ? lat_cnt + LAT_W'(1) : '0;
      if (fire_line || fire_char) gap_cnt <= GAP_W'(1);
      else if (!gap_ok)           gap_cnt <= gap_cnt + GAP_W'(1);
      if (addr_inc)    text_addr <= text_addr + ADDR_W'(1);
      if (ret_load)    ret_state <= ret_nx;
      if (set_closing) closing   <= 1'b1;
      if (state == S_DECODE) begin
        emit_byte <= nz_byte;
        if (nz_comment) comment_mode <= 1'b1;
      end
      if (fire_char) begin
        incoming_character <= char_val;
        char_count         <= chars[CHAR_W-1:0];
        chars              <= chars + (CHAR_W + 1)'(1);
      end
      if (fire_line) begin
        line_count   <= first_line ? '0 : line_count + LINE_W'(1);
        first_line   <= 1'b0;
        char_count   <= '0;
        chars        <= '0;
        comment_mode <= 1'b0;
      end
      if (abort) begin
        error_flag <= 1'b1;
        error_line <= line_count;
      end
      if (state == S_FINISH) begin
        assembler_state <= FINISHED;
        busy            <= 1'b0;
        done            <= 1'b1;
      end
      if (restart) begin
        assembler_state <= INSTRUCTION_MAPPING;
        text_addr       <= '0;
        line_count      <= '0;
        char_count      <= '0;
        chars           <= '0;
        first_line      <= 1'b1;
        closing         <= 1'b0;
        comment_mode    <= 1'b0;
      end
      if (accept) begin
        assembler_state <= PC_MAPPING;
        busy            <= 1'b1;
        error_flag      <= 1'b0;
        text_addr       <= '0;
        line_count      <= '0;
        char_count      <= '0;
        chars           <= '0;
        first_line      <= 1'b1;
        closing         <= 1'b0;
        comment_mode    <= 1'b0;
        gap_cnt         <= GAP_FULL;
      end
    end
  end

endmodule

// File: tb/tb_source_streamer.sv
// tb/tb_source_streamer.sv - randomized self-checking bench for source_streamer
module tb_source_streamer;
  import source_streamer_pkg::*;

  localparam int CPL = 64;
  localparam int NL = 256;
  localparam int LAT = 2;
  localparam int GAP = 4;
  localparam int DEPTH = CPL * NL;

  logic clk_in, rst_in, start_in, error_in;
  logic [13:0] text_addr;
  logic [7:0] text_data, incoming_character;
  logic new_line, new_character, busy, done, error_flag;
  logic [7:0] line_count, error_line;
  logic [5:0] char_count;
  assembler_state_t assembler_state;

  source_streamer #(.CHAR_PER_LINE(CPL), .NUMBER_LINES(NL), .BRAM_LATENCY(LAT), .CHAR_GAP(GAP)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .text_addr(text_addr),
    .text_data(text_data), .new_line(new_line), .new_character(new_character),
    .incoming_character(incoming_character), .line_count(line_count), .char_count(char_count),
    .assembler_state(assembler_state), .error_in(error_in), .busy(busy), .done(done),
    .error_flag(error_flag), .error_line(error_line)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  logic [7:0] mem [0:DEPTH-1];
  logic [7:0] pipe [0:LAT-1];
  always @(posedge clk_in) begin
    pipe[0] <= mem[text_addr];
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign text_data = pipe[LAT-1];

  typedef struct {
    bit is_char;
    int ch;
    int line;
    int cc;
    assembler_state_t st;
  } evt_t;

  evt_t exp_q[$];
  logic [7:0] txt[$];
  int checks = 0;
  int errors = 0;
  bit model_err;
  int model_err_line;
  bit stop_expect = 0;

  task automatic check(input string name, input bit ok, input int act, input int req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Reference: walk the text as a byte stream and list the pulses each pass must produce
  task automatic model_char(input int c, input int line, inout int n, input assembler_state_t st, inout bit err);
    evt_t e;
    if (err) return;
    if (n >= CPL) begin err = 1; return; end
    e.is_char = 1; e.ch = c; e.line = line; e.cc = n; e.st = st;
    exp_q.push_back(e);
    n++;
  endtask

  task automatic model_line(inout int line, inout int n, input bit first, input assembler_state_t st, inout bit err);
    evt_t e;
    if (err) return;
    if (!first) begin
      if (line == NL - 1) begin err = 1; return; end
      line++;
    end
    e.is_char = 0; e.ch = 0; e.line = line; e.cc = 0; e.st = st;
    exp_q.push_back(e);
    n = 0;
  endtask

  task automatic build_model();
    int line, n, addr, b;
    bit comment, err, fin;
    assembler_state_t st;
    exp_q.delete();
    model_err = 0;
    model_err_line = 0;
    for (int p = 0; p < 2 && !model_err; p++) begin
      st = (p == 0) ? PC_MAPPING : INSTRUCTION_MAPPING;
      line = 0; n = 0; addr = 0; comment = 0; err = 0; fin = 0;
      model_line(line, n, 1, st, err);
      while (!fin && !err) begin
        b = mem[addr];
        if (addr == DEPTH - 1 || b == 0) begin
          if (n > 0) model_char(32, line, n, st, err);
          model_line(line, n, 0, st, err);
          fin = 1;
        end else if (b == 10) begin
          if (n > 0) model_char(32, line, n, st, err);
          model_line(line, n, 0, st, err);
          comment = 0;
          addr++;
        end else if (comment || b == 13) begin
          addr++;
        end else if (b == 35) begin
          comment = 1;
          addr++;
        end else begin
          model_char((b == 9) ? 32 : b, line, n, st, err);
          addr++;
        end
      end
      if (err) begin
        model_err = 1;
        model_err_line = line;
      end
    end
  endtask

  task automatic add_str(input string s);
    for (int i = 0; i < s.len(); i++) txt.push_back(s[i]);
  endtask

  task automatic load_text();
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;
    for (int i = 0; i < txt.size(); i++) mem[i] = txt[i];
    build_model();
  endtask

  task automatic gen_random();
    int nlines, len, r, c;
    txt.delete();
    nlines = $urandom_range(1, 8);
    for (int l = 0; l < nlines; l++) begin
      len = ($urandom_range(0, 9) == 0) ? $urandom_range(55, 75) : $urandom_range(0, 20);
      for (int k = 0; k < len; k++) begin
        r = $urandom_range(0, 99);
        if (r < 8)       c = 9;
        else if (r < 12) c = 35;
        else if (r < 17) c = 13;
        else if (r < 26) c = 32;
        else begin
          c = $urandom_range(33, 126);
          if (c == 35) c = 36;
        end
        txt.push_back(8'(c));
      end
      if (l < nlines - 1 || $urandom_range(0, 1) == 1) txt.push_back(8'h0A);
    end
    load_text();
  endtask

  int cyc = 0;
  int last_cyc = 0;
  bit has_last = 0;
  evt_t cur;
  always @(negedge clk_in) begin
    cyc++;
    if (rst_in) begin
      has_last = 0;
    end else if (new_line || new_character) begin
      check("no_overlap", !(new_line && new_character), 1, 0);
      if (has_last) check("pulse_gap", (cyc - last_cyc) >= GAP, cyc - last_cyc, GAP);
      last_cyc = cyc;
      has_last = 1;
      if (stop_expect) begin
        check("pulse_after_error", 0, 1, 0);
      end else if (exp_q.size() == 0) begin
        check("unexpected_pulse", 0, 1, 0);
      end else begin
        cur = exp_q.pop_front();
        check("pulse_kind", new_character == cur.is_char, new_character, cur.is_char);
        check("line_count", line_count == cur.line, line_count, cur.line);
        check("asm_state", assembler_state == cur.st, assembler_state, cur.st);
        if (cur.is_char) begin
          check("char_value", incoming_character == cur.ch, incoming_character, cur.ch);
          check("char_count", char_count == cur.cc, char_count, cur.cc);
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_new_line"}, new_line == 0, new_line, 0);
    check({tag, "_new_char"}, new_character == 0, new_character, 0);
    check({tag, "_busy"}, busy == 0, busy, 0);
    check({tag, "_done"}, done == 0, done, 0);
    check({tag, "_err_flag"}, error_flag == 0, error_flag, 0);
    check({tag, "_state"}, assembler_state == IDLE, assembler_state, IDLE);
    check({tag, "_addr"}, text_addr == 0, text_addr, 0);
    check({tag, "_line"}, line_count == 0, line_count, 0);
    check({tag, "_charcnt"}, char_count == 0, char_count, 0);
    check({tag, "_char"}, incoming_character == 0, incoming_character, 0);
    check({tag, "_err_line"}, error_line == 0, error_line, 0);
  endtask

  task automatic start_pass(input string name);
    stop_expect = 0;
    repeat (GAP + 1) @(negedge clk_in);
    start_in = 1;
    @(negedge clk_in);
    start_in = 0;
    check({name, "_busy_on"}, busy == 1, busy, 1);
    check({name, "_state_pc"}, assembler_state == PC_MAPPING, assembler_state, PC_MAPPING);
    check({name, "_flag_clr"}, error_flag == 0, error_flag, 0);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 40000) begin
      @(negedge clk_in);
      n++;
    end
    check({name, "_done_seen"}, done == 1, done, 1);
  endtask

  task automatic finish_checks(input string name, input bit exp_err, input int exp_line);
    check({name, "_err_flag"}, error_flag == exp_err, error_flag, exp_err);
    if (exp_err) check({name, "_err_line"}, error_line == exp_line, error_line, exp_line);
    check({name, "_state_fin"}, assembler_state == FINISHED, assembler_state, FINISHED);
    check({name, "_busy_off"}, busy == 0, busy, 0);
    @(negedge clk_in);
    check({name, "_done_1cyc"}, done == 0, done, 0);
    check({name, "_state_hold"}, assembler_state == FINISHED, assembler_state, FINISHED);
  endtask

  task automatic run_case(input string name);
    start_pass(name);
    wait_done(name);
    check({name, "_all_pulses"}, exp_q.size() == 0, exp_q.size(), 0);
    finish_checks(name, model_err, model_err_line);
  endtask

  initial begin
    int n;
    rst_in = 1; start_in = 0; error_in = 0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;
    repeat (3) @(negedge clk_in);
    check_all_zero("reset");
    rst_in = 0;

    txt.delete();
    add_str("addi x1,x0,5\n");
    load_text();
    check("m1_count", exp_q.size() == 32, exp_q.size(), 32);
    check("m1_delim", exp_q[13].ch == 32 && exp_q[13].cc == 12, exp_q[13].cc, 12);
    check("m1_last_line", exp_q[31].line == 2, exp_q[31].line, 2);
    run_case("addi");

    txt.delete();
    add_str("a\t#x\015\nb");
    load_text();
    check("m2_count", exp_q.size() == 16, exp_q.size(), 16);
    check("m2_tab", exp_q[2].ch == 32 && exp_q[2].cc == 1, exp_q[2].ch, 32);
    run_case("norm");
    check("norm_final_line", line_count == 2, line_count, 2);

    txt.delete();
    add_str("l0\nl1\nl2\nthird line\nl4 x\n");
    load_text();
    start_pass("errin");
    n = 0;
    while (!(new_line && line_count == 3 && assembler_state == INSTRUCTION_MAPPING) && n < 40000) begin
      @(negedge clk_in);
      n++;
    end
    check("errin_line3_seen", n < 40000, n, 0);
    error_in = 1;
    @(negedge clk_in);
    error_in = 0;
    stop_expect = 1;
    wait_done("errin");
    finish_checks("errin", 1, 3);
    exp_q.delete();

    txt.delete();
    add_str("ab\n");
    for (int i = 0; i < 70; i++) txt.push_back(8'h78);
    add_str("\n");
    load_text();
    check("m3_count", exp_q.size() == 69, exp_q.size(), 69);
    check("m3_err_line", model_err == 1 && model_err_line == 1, model_err_line, 1);
    run_case("ovf");

    txt.delete();
    add_str("x\ty\n\nz");
    load_text();
    run_case("after_err");

    txt.delete();
    add_str("add x2,x2,x3\nsub x4,x5,x6\n");
    load_text();
    start_pass("rst");
    repeat (60) @(negedge clk_in);
    #2 rst_in = 1;
    #1 check_all_zero("async_rst");
    exp_q.delete();
    @(negedge clk_in);
    rst_in = 0;
    build_model();
    run_case("replay");

    for (int k = 0; k < 15; k++) begin
      gen_random();
      run_case($sformatf("rand%0d", k));
    end

    repeat (5) @(negedge clk_in);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
